// File: rtl/seg7_bin_display.sv
// ============================================================================
// Module   : seg7_bin_display
// Brief    : Binary to multi-digit active-low 7-segment display controller
//            using a sequential double-dabble conversion engine.
//            Optional leading-zero blanking: define SEG7_LZB_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_bin_display #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [WIDTH-1:0]      value,
    output logic [7*DIGITS-1:0]   hex,
    output logic                  overflow
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        UPDATE  = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   shreg;
    logic [BCD_W-1:0]   bcd;
    logic [CNT_W-1:0]   cnt;
    logic               sticky;

    logic [BCD_W-1:0]   bcd_adj;
    logic [7*DIGITS-1:0] hex_next;
    logic [3:0]         digit;
`ifdef SEG7_LZB_EN
    logic               seen_nonzero;
`endif

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'b1000000;
            4'd1:    seg_code = 7'b1111001;
            4'd2:    seg_code = 7'b0100100;
            4'd3:    seg_code = 7'b0110000;
            4'd4:    seg_code = 7'b0011001;
            4'd5:    seg_code = 7'b0010010;
            4'd6:    seg_code = 7'b0000010;
            4'd7:    seg_code = 7'b1111000;
            4'd8:    seg_code = 7'b0000000;
            4'd9:    seg_code = 7'b0011000;
            default: seg_code = SEG_BLANK;
        endcase
    endfunction

    // Nibbles never exceed 9, so +3 always fits in four bits.
    always_comb begin
        bcd_adj = bcd;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd[4*k +: 4] >= 4'd5)
                bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
        end
    end

    // Scan from the most significant digit so blanking stops at the first nonzero.
    always_comb begin
        hex_next = '1;
        digit    = '0;
`ifdef SEG7_LZB_EN
        seen_nonzero = 1'b0;
`endif
        for (int k = DIGITS - 1; k >= 0; k--) begin
            digit = bcd[4*k +: 4];
            if (sticky) begin
                hex_next[7*k +: 7] = SEG_DASH;
            end else begin
`ifdef SEG7_LZB_EN
                if (digit != 4'd0 || k == 0)
                    seen_nonzero = 1'b1;
                hex_next[7*k +: 7] = seen_nonzero ? seg_code(digit) : SEG_BLANK;
`else
                hex_next[7*k +: 7] = seg_code(digit);
`endif
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            load_ready <= 1'b1;
            shreg      <= '0;
            bcd        <= '0;
            cnt        <= '0;
            sticky     <= 1'b0;
            hex        <= '1;
            overflow   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_valid && load_ready) begin
                        shreg      <= value;
                        bcd        <= '0;
                        sticky     <= 1'b0;
                        cnt        <= CNT_W'(WIDTH);
                        load_ready <= 1'b0;
                        state      <= CONVERT;
                    end
                end
                CONVERT: begin
                    {bcd, shreg} <= {bcd_adj[BCD_W-2:0], shreg, 1'b0};
                    sticky       <= sticky | bcd_adj[BCD_W-1];
                    cnt          <= cnt - 1'b1;
                    if (cnt == CNT_W'(1))
                        state <= UPDATE;
                end
                UPDATE: begin
                    hex        <= hex_next;
                    overflow   <= sticky;
                    load_ready <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    state      <= IDLE;
                    load_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seg7_bin_display.sv
// ============================================================================
// Module   : tb_seg7_bin_display
// Brief    : Self-checking bench for seg7_bin_display (5-digit and 4-digit
//            instances sharing one stimulus stream).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg7_bin_display;

    localparam int WIDTH = 16;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                           S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                           S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                           S9 = 7'b0011000, SB = 7'b1111111, SD = 7'b0111111;
    localparam logic [6:0] SEG_TAB [10] = '{S0, S1, S2, S3, S4, S5, S6, S7, S8, S9};

`ifdef SEG7_LZB_EN
    localparam bit LZB = 1'b1;
    localparam logic [6:0] LZ = SB;
`else
    localparam bit LZB = 1'b0;
    localparam logic [6:0] LZ = S0;
`endif

    logic             clock;
    logic             resetn;
    logic             load_valid;
    logic [WIDTH-1:0] value;
    logic             ready5, ready4;
    logic [34:0]      hex5;
    logic [27:0]      hex4;
    logic             ov5, ov4;

    int n_tests = 0;
    int n_fail  = 0;

    seg7_bin_display #(.WIDTH(WIDTH), .DIGITS(5)) u_dut5 (
        .clock(clock), .resetn(resetn), .load_valid(load_valid), .load_ready(ready5),
        .value(value), .hex(hex5), .overflow(ov5)
    );

    seg7_bin_display #(.WIDTH(WIDTH), .DIGITS(4)) u_dut4 (
        .clock(clock), .resetn(resetn), .load_valid(load_valid), .load_ready(ready4),
        .value(value), .hex(hex4), .overflow(ov4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Decimal display of v on nd digits, computed directly from arithmetic.
    function automatic logic [34:0] model_hex(input int unsigned v, input int nd);
        int unsigned p;
        int unsigned lim;
        logic [34:0] r;
        lim = 1;
        for (int k = 0; k < nd; k++) lim = lim * 10;
        r = '1;
        p = 1;
        for (int k = 0; k < nd; k++) begin
            if (v >= lim)                    r[7*k +: 7] = SD;
            else if (LZB && k > 0 && v < p)  r[7*k +: 7] = SB;
            else                             r[7*k +: 7] = SEG_TAB[(v / p) % 10];
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic model_ov(input int unsigned v, input int nd);
        int unsigned lim;
        lim = 1;
        for (int k = 0; k < nd; k++) lim = lim * 10;
        return v >= lim;
    endfunction

    task automatic check(input string name, input logic [34:0] act, input logic [34:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference timing: an accepted value appears WIDTH+1 edges later.
    logic        m_valid = 1'b0;
    logic        m_ready;
    int          m_busy;
    int unsigned m_cap;
    logic [34:0] m_hex5;
    logic [27:0] m_hex4;
    logic        m_ov5, m_ov4;

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            m_valid <= 1'b1;
            m_ready <= 1'b1;
            m_busy  <= 0;
            m_hex5  <= '1;
            m_hex4  <= '1;
            m_ov5   <= 1'b0;
            m_ov4   <= 1'b0;
        end else if (m_ready && load_valid) begin
            m_cap   <= int'(value);
            m_busy  <= WIDTH + 1;
            m_ready <= 1'b0;
        end else if (!m_ready) begin
            if (m_busy == 1) begin
                m_hex5  <= model_hex(m_cap, 5);
                m_hex4  <= 28'(model_hex(m_cap, 4));
                m_ov5   <= model_ov(m_cap, 5);
                m_ov4   <= model_ov(m_cap, 4);
                m_ready <= 1'b1;
            end
            m_busy <= m_busy - 1;
        end
    end

    always @(negedge clock) begin
        if (m_valid) begin
            check("cyc_ready5", 35'(ready5), 35'(m_ready));
            check("cyc_ready4", 35'(ready4), 35'(m_ready));
            check("cyc_hex5",   hex5,        m_hex5);
            check("cyc_hex4",   35'(hex4),   35'(m_hex4));
            check("cyc_ov5",    35'(ov5),    35'(m_ov5));
            check("cyc_ov4",    35'(ov4),    35'(m_ov4));
        end
    end

    // Present v at a negedge where the DUT is ready; accept on the next posedge.
    task automatic send(input logic [WIDTH-1:0] v);
        int guard;
        guard = 0;
        @(negedge clock);
        while (!ready5 && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 100) check("send_timeout", 35'(ready5), 35'(1));
        load_valid = 1'b1;
        value      = v;
        @(posedge clock);
        #1;
        load_valid = 1'b0;
        value      = WIDTH'($urandom);
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        @(negedge clock);
        while (!ready5 && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 100) check("idle_timeout", 35'(ready5), 35'(1));
    endtask

    task automatic load(input logic [WIDTH-1:0] v);
        send(v);
        wait_idle();
    endtask

    int acc_at [4];
    int n_acc;

    initial begin
        resetn     = 1'b0;
        load_valid = 1'b0;
        value      = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;

        check("rst_hex5", hex5, '1);
        check("rst_ov5", 35'(ov5), 35'(0));
        check("rst_ready", 35'(ready5), 35'(1));

        load(16'd1234);
        check("lit_1234_hex5", hex5, {LZ, S1, S2, S3, S4});
        check("lit_1234_ov5", 35'(ov5), 35'(0));

        load(16'd65535);
        check("lit_65535_hex4", 35'(hex4), 35'({SD, SD, SD, SD}));
        check("lit_65535_ov4", 35'(ov4), 35'(1));
        check("lit_65535_hex5", hex5, {S6, S5, S5, S3, S5});

        load(16'd9999);
        check("lit_9999_hex4", 35'(hex4), 35'({S9, S9, S9, S9}));
        check("lit_9999_ov4", 35'(ov4), 35'(0));

        load(16'd0);
        check("lit_0_hex5", hex5, {LZ, LZ, LZ, LZ, S0});

        load(16'd10000);
        check("lit_10000_hex5", hex5, {S1, S0, S0, S0, S0});
        check("lit_10000_ov4", 35'(ov4), 35'(1));

        // Asynchronous reset in the middle of a conversion.
        send(16'd777);
        repeat (5) @(negedge clock);
        #2 resetn = 1'b0;
        #1;
        check("arst_hex5", hex5, '1);
        check("arst_hex4", 35'(hex4), 35'({28{1'b1}}));
        check("arst_ov4", 35'(ov4), 35'(0));
        check("arst_ready", 35'(ready5), 35'(1));
        @(negedge clock);
        resetn = 1'b1;
        load(16'd42);
        check("lit_42_hex5", hex5, {LZ, LZ, LZ, S4, S2});

        // load_valid held high with value changing every cycle.
        @(negedge clock);
        n_acc      = 0;
        load_valid = 1'b1;
        value      = WIDTH'($urandom);
        for (int i = 0; i < 40; i++) begin
            if (ready5) begin
                if (n_acc < 4) acc_at[n_acc] = i;
                n_acc++;
            end
            @(posedge clock);
            #1 value = WIDTH'($urandom);
            @(negedge clock);
        end
        load_valid = 1'b0;
        check("b2b_count", 35'(n_acc), 35'(3));
        check("b2b_gap1", 35'(acc_at[1] - acc_at[0]), 35'(WIDTH + 2));
        check("b2b_gap2", 35'(acc_at[2] - acc_at[1]), 35'(WIDTH + 2));
        wait_idle();

        // Randomized loads, including ignored requests during conversion.
        for (int n = 0; n < 40; n++) begin
            logic [WIDTH-1:0] v;
            case ($urandom_range(0, 5))
                0:       v = 16'd0;
                1:       v = 16'd9999;
                2:       v = 16'd10000;
                3:       v = 16'd65535;
                default: v = WIDTH'($urandom);
            endcase
            send(v);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 4)) @(negedge clock);
                load_valid = 1'b1;
                value      = WIDTH'($urandom);
                repeat ($urandom_range(1, 5)) @(negedge clock);
                load_valid = 1'b0;
            end
            wait_idle();
            repeat ($urandom_range(0, 3)) @(negedge clock);
        end

        repeat (2) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seg7_bin_display.md
# seg7_bin_display

Parametrised binary-to-decimal 7-segment display controller. Accepts an unsigned binary value through a valid/ready handshake, converts it to BCD with a sequential shift-add-3 (double-dabble) engine, and drives `DIGITS` registered active-low 7-segment fields. Sits between the datapath (register/result values) and the board HEX displays. It replaces per-digit combinational decoders with one block that handles multi-digit decimal output, overflow indication and leading-zero blanking.

## Interface
- `WIDTH`, 16, bit width of the input value; must be ≥ 4.
- `DIGITS`, 5, number of decimal digits driven; must be ≥ 1.

- `clock`  in  1  system clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `load_valid`  in  1  request to display `value`.
- `load_ready`  out  1  high when a new value can be accepted.
- `value`  in  WIDTH  unsigned binary value to display.
- `hex`  out  7*DIGITS  segment fields. Digit k (k=0 is least significant) occupies `hex[7k+6:7k]`, with bit order g,f,e,d,c,b,a from MSB to LSB. Segments are active-low.
- `overflow`  out  1  registered; high when the last displayed value was ≥ 10^DIGITS.

## Operation
- Segment codes (g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000
  - blank=1111111, dash=0111111
- FSM states:
  - IDLE: `load_ready`=1.
  - CONVERT: `load_ready`=0.
  - UPDATE: `load_ready`=0.
- IDLE → CONVERT on `load_valid && load_ready`:
  - Capture `value` into the shift register.
  - Clear the 4*DIGITS BCD register and the sticky overflow bit.
  - Load the bit counter with WIDTH.
- Each CONVERT cycle:
  - Add 3 to every BCD nibble ≥ 5.
  - Shift {BCD, shift register} left by one.
  - If the bit shifted out of the top BCD nibble is 1, set the sticky overflow bit.
  - Decrement the counter.
  - Go to UPDATE when the counter reaches 0 (after exactly WIDTH shifts).
- UPDATE: decode all digits into `hex` in a single edge, copy the sticky bit to `overflow`, then return to IDLE.
- Overflow set: every digit shows dash; blanking is not applied.
- `hex` holds the previous result throughout CONVERT, so the display never shows partial digits.
- `load_valid` outside IDLE is ignored; no value is queued. The source must hold `load_valid` until it sees `load_ready`.
- Arithmetic: the value is unsigned; BCD nibbles are 4 bits each; no other sign or width extension is applied.

## Timing
- Reset (asynchronous, any state):
  - FSM to IDLE; `load_ready`=1.
  - All digits blank (1111111); `overflow`=0.
  - Any in-progress conversion is discarded.
- Accept edge t → WIDTH shift edges t+1..t+WIDTH → `hex`/`overflow` update at edge t+WIDTH+1.
- `load_ready` is high again after edge t+WIDTH+1, so the next accept can occur at edge t+WIDTH+2.
- Throughput: one value per WIDTH+2 cycles.
- Back-to-back: `load_valid` held high continuously gives accepts spaced exactly WIDTH+2 cycles apart.
- Value 0 takes the same latency as any other value.
- `value` is sampled only on the accept edge. Changes after that edge do not affect the current conversion.

## Configuration
- `SEG7_LZB_EN` defined (leading-zero blanking):
  - In UPDATE, every zero digit above the most significant nonzero digit is blank.
  - Digit 0 is never blanked, so value 0 shows "0".
- `SEG7_LZB_EN` undefined: every digit shows its decimal value, including leading zeros.
- Overflow dashes behave the same in both builds.

## Test plan
- Reset: assert `resetn`=0 mid-CONVERT → all `hex` fields = 1111111, `overflow`=0, `load_ready`=1 immediately, without waiting for a clock edge.
- WIDTH=16, DIGITS=5, value=1234, LZB on:
  - Before edge t+17: `hex` still shows the old value.
  - At edge t+17: digits 4..0 = blank, 1111001, 0100100, 0110000, 0011001.
  - With LZB off, digit 4 = 1000000.
- WIDTH=16, DIGITS=4, value=65535 → all four digits = 0111111, `overflow`=1. A following value of 9999 → 0011000 on all digits, `overflow`=0.
- value=0, LZB on → digit 0 = 1000000, digits 1..4 blank. value=10000 → digit 4 = 1111001, digits 3..0 = 1000000.
- `load_valid` held high with the value changing every cycle → accepts only at edges t, t+18, t+36. Each display equals the value sampled at the matching accept edge.
- Reset pulse during CONVERT, then load 42 → after 17 cycles the display shows 42 (digits 1..0 = 0011001, 0100100). No residue from the aborted conversion appears.
